gaxi_skid_buffer_multi_lane: RTL and testbench
==============================================

GAXI_SKID_BUFFER_MULTI_LANE -- requirements
Module: gaxi_skid_buffer_multi_lane

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named axi_aclk and axi_areset.
REQ-002 The block SHALL provide these parameters, one per line as name, default, meaning:
- ADDR_WIDTH, 4, address field width.
- CTRL_WIDTH, 4, control field width.
- DATA_WIDTH, 8, width of one data lane.
- NUM_LANES, 2, number of data lanes (legal range 1..8).
- DEPTH, 2, entry count (legal values 2, 4, 6, 8).
- AFULL_LEVEL, DEPTH-1, threshold for wr_almost_full (legal range 1..DEPTH).
REQ-003 The block SHALL provide these ports, one per line as name, direction, width, meaning:
- axi_aclk  in  1  clock.
- axi_areset  in  1  async reset, active high.
- flush  in  1  synchronous discard of all stored entries.
- wr_valid  in  1  write request.
- wr_ready  out  1  space available.
- wr_addr  in  ADDR_WIDTH  address field.
- wr_ctrl  in  CTRL_WIDTH  control field.
- wr_data  in  NUM_LANES*DATA_WIDTH  lane data, lane 0 at LSBs.
- rd_valid  out  1  head entry valid.
- rd_ready  in  1  consumer accept.
- rd_addr  out  ADDR_WIDTH  head address.
- rd_ctrl  out  CTRL_WIDTH  head control.
- rd_data  out  NUM_LANES*DATA_WIDTH  head lane data.
- count  out  $clog2(DEPTH+1)  stored entries.
- wr_almost_full  out  1  count >= AFULL_LEVEL.

Function
REQ-004 Storage SHALL be a circular buffer of DEPTH entries, each {addr, ctrl, lane N-1 .. lane 0}, implemented in this block without instantiating another skid buffer.
REQ-005 Write pointer and read pointer SHALL each wrap from DEPTH-1 to 0; there SHALL be no power-of-two assumption.
REQ-006 wr_ready SHALL be driven from registered state only, and SHALL equal (count < DEPTH) AND NOT flush.
REQ-007 A write SHALL occur on a rising edge where wr_valid AND wr_ready.
REQ-008 A read SHALL occur on a rising edge where rd_valid AND rd_ready.
REQ-009 rd_valid SHALL equal (count != 0), driven from a register.
REQ-010 rd_addr, rd_ctrl and rd_data SHALL present the head entry from registered state, with no combinational path from the wr_* inputs.
REQ-011 A write accepted at edge N SHALL make rd_valid high after edge N when the buffer was empty; minimum latency is 1 cycle and there is no bypass.
REQ-012 When a write and a read occur at the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-013 A write and a read at the same edge SHALL be legal at any count from 1 to DEPTH-1.
REQ-014 At count = DEPTH, wr_ready SHALL be 0 even if rd_ready = 1; the read frees the slot for the next cycle only.
REQ-015 At count = 0, rd_ready SHALL be ignored and count SHALL NOT underflow.
REQ-016 The block SHALL never write when full nor read when empty, and no input sequence SHALL corrupt count.
REQ-017 Output ordering SHALL be strict FIFO, and all fields of an entry SHALL travel together.
REQ-018 A flush sampled high at edge N SHALL drop any write and read at edge N and set count=0 with both pointers 0 after edge N.
REQ-019 After a flush at edge N, rd_valid SHALL be 0 from edge N until a new write.
REQ-020 wr_almost_full SHALL be registered and SHALL be consistent with count in the same cycle.
REQ-021 rd_* data outputs SHALL be don't-care when rd_valid=0; the bench SHALL NOT check them.

Reset
REQ-022 While axi_areset is high, the block SHALL hold count=0, pointers=0, rd_valid=0, wr_ready=0 and wr_almost_full=0.
REQ-023 While axi_areset is high, rd_addr, rd_ctrl and rd_data SHALL be 0.
REQ-024 Assertion of axi_areset SHALL take effect immediately, without waiting for a clock edge.
REQ-025 Assertion of axi_areset mid-transfer SHALL discard all contents.
REQ-026 wr_ready SHALL rise on the first axi_aclk edge after axi_areset deasserts.
REQ-027 Storage contents other than the output registers need not be reset.

Verification (DATA_WIDTH=8, NUM_LANES=4, DEPTH=4, AFULL_LEVEL=3)
REQ-028 Fill: 4 writes with rd_ready=0 -> count 1,2,3,4; wr_almost_full rises at count=3; wr_ready=0 at count=4; 5th wr_valid is not accepted.
REQ-029 Drain order: writes with wr_data 0x44332211, 0x88776655, 0xCCBBAA99 -> reads return the same values in order, with lane 0 = 0x11, 0x55, 0x99.
REQ-030 Streaming: wr_valid=rd_ready=1 continuously for 20 cycles after the first write -> count holds 1; a throughput of 1 entry/cycle SHALL be checked.
REQ-031 Full and read: at count=4, rd_ready=1 with wr_valid=1 -> edge 1 is a read only (count 3); edge 2 is a write and read (count 3).
REQ-032 Flush: count=3, then flush=1 with wr_valid=1 for 1 cycle -> count=0, rd_valid=0, and the written entry is absent afterwards.
REQ-033 Async reset: assert axi_areset mid-cycle at count=2 -> rd_valid and count are 0 before the next edge; after release, a write of 0xDEADBEEF reads back first.

Source files
------------

// File: rtl/gaxi_skid_buffer_multi_lane.sv
// Multi-lane circular-buffer skid buffer: DEPTH entries of {addr, ctrl, lanes},
// registered head presentation, synchronous flush and asynchronous reset.
module gaxi_skid_buffer_multi_lane #(
    parameter int ADDR_WIDTH  = 4,
    parameter int CTRL_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_LANES   = 2,
    parameter int DEPTH       = 2,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                              axi_aclk,
    input  logic                              axi_areset,
    input  logic                              flush,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [CTRL_WIDTH-1:0]             wr_ctrl,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   wr_data,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    output logic [CTRL_WIDTH-1:0]             rd_ctrl,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic                              wr_almost_full
);

    localparam int LANE_W  = NUM_LANES * DATA_WIDTH;
    localparam int ENTRY_W = ADDR_WIDTH + CTRL_WIDTH + LANE_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [ENTRY_W-1:0] head_r;
    logic [ENTRY_W-1:0] head_nxt_s;
    logic [ENTRY_W-1:0] wr_entry_s;
    logic               wr_ready_r;
    logic               rd_valid_r;
    logic               afull_r;
    logic               do_wr_s;
    logic               do_rd_s;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    assign wr_entry_s = {wr_addr, wr_ctrl, wr_data};
    assign do_wr_s    = wr_valid & wr_ready_r & ~flush;
    assign do_rd_s    = rd_valid_r & rd_ready & ~flush;

    // Next pointers, occupancy and head entry for the coming edge.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;
        if (flush) begin
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (do_rd_s) begin
                rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
        // A head slot being written this very edge is not yet in memory.
        if (do_wr_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = wr_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Control state and registered head outputs.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            head_r     <= {ENTRY_W{1'b0}};
            wr_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
            afull_r    <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            count_r    <= count_nxt_s;
            head_r     <= head_nxt_s;
            wr_ready_r <= (count_nxt_s < CNT_W'(DEPTH));
            rd_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            afull_r    <= (count_nxt_s >= CNT_W'(AFULL_LEVEL));
        end
    end

    // Entry storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge axi_aclk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    assign wr_ready       = wr_ready_r & ~flush;
    assign rd_valid       = rd_valid_r;
    assign count          = count_r;
    assign wr_almost_full = afull_r;
    assign rd_addr        = head_r[ENTRY_W-1 -: ADDR_WIDTH];
    assign rd_ctrl        = head_r[LANE_W +: CTRL_WIDTH];
    assign rd_data        = head_r[LANE_W-1:0];

endmodule

// File: tb/tb_gaxi_skid_buffer_multi_lane.sv
// Bench for gaxi_skid_buffer_multi_lane: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_gaxi_skid_buffer_multi_lane;

    localparam int AW = 4;
    localparam int CW = 4;
    localparam int DW = 8;
    localparam int NL = 4;
    localparam int DP = 4;
    localparam int AF = 3;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic          flush;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_ctrl;
    logic [31:0]   wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rd_ctrl;
    logic [31:0]   rd_data;
    logic [2:0]    count;
    logic          wr_almost_full;

    gaxi_skid_buffer_multi_lane #(
        .ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .DATA_WIDTH(DW),
        .NUM_LANES(NL), .DEPTH(DP), .AFULL_LEVEL(AF)
    ) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_ctrl(wr_ctrl), .wr_data(wr_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_ctrl(rd_ctrl),
        .rd_data(rd_data), .count(count), .wr_almost_full(wr_almost_full)
    );

    always #5 axi_aclk = ~axi_aclk;

    logic [39:0] q[$];
    bit          ready_m;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_rd_hs = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("wr_ready", wr_ready, ready_m && (q.size() < DP) && !flush);
        check_val("rd_valid", rd_valid, q.size() != 0);
        check_val("count", count, q.size());
        check_val("afull", wr_almost_full, q.size() >= AF);
        if (axi_areset) begin
            check_val("rst_addr", rd_addr, 0);
            check_val("rst_ctrl", rd_ctrl, 0);
            check_val("rst_data", rd_data, 0);
        end else if (q.size() > 0) begin
            check_val("rd_addr", rd_addr, q[0][39:36]);
            check_val("rd_ctrl", rd_ctrl, q[0][35:32]);
            check_val("rd_data", rd_data, q[0][31:0]);
            check_val("lane0", rd_data[7:0], q[0][7:0]);
        end
    endtask

    // One clock: drive, check just before the edge, then advance the model.
    task automatic cycle(input logic wv, input logic [31:0] wd, input logic [3:0] wa,
                         input logic [3:0] wc, input logic rr, input logic fl);
        bit w;
        bit r;
        wr_valid = wv; wr_data = wd; wr_addr = wa; wr_ctrl = wc;
        rd_ready = rr; flush = fl;
        #1;
        check_outputs();
        if (rd_valid && rd_ready) n_rd_hs++;
        @(posedge axi_aclk);
        if (axi_areset) begin
            q.delete();
            ready_m = 1'b0;
        end else if (fl) begin
            q.delete();
            ready_m = 1'b1;
        end else begin
            w = wv && ready_m && (q.size() < DP);
            r = rr && (q.size() > 0);
            if (r) void'(q.pop_front());
            if (w) q.push_back({wa, wc, wd});
            ready_m = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 32'h0, 4'h0, 4'h0, rr, 1'b0);
    endtask

    task automatic put(input logic [31:0] d, input logic rr);
        cycle(1'b1, d, d[3:0], d[7:4], rr, 1'b0);
    endtask

    initial begin
        axi_areset = 1'b1;
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        wr_data = 32'h0; wr_addr = 4'h0; wr_ctrl = 4'h0;
        ready_m = 1'b0;
        #1;
        idle(1'b1);
        idle(1'b0);
        axi_areset = 1'b0;
        idle(1'b0);
        idle(1'b0);

        // Fill to full, then offer a fifth write.
        for (int i = 0; i < 5; i++) put(32'h1000_0000 + 32'(i), 1'b0);
        idle(1'b0);
        // Full and read: read-only edge, then simultaneous write and read.
        put(32'hA5A5_0001, 1'b1);
        put(32'hA5A5_0002, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Drain order with distinct lane patterns.
        put(32'h4433_2211, 1'b0);
        put(32'h8877_6655, 1'b0);
        put(32'hCCBB_AA99, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Streaming: one entry in, one out per cycle.
        put(32'h5000_0000, 1'b0);
        n_rd_hs = 0;
        for (int i = 0; i < 20; i++) put(32'h5000_0001 + 32'(i), 1'b1);
        check_val("thruput", n_rd_hs, 20);
        for (int i = 0; i < 2; i++) idle(1'b1);

        // Flush at count 3 while a write is offered.
        for (int i = 0; i < 3; i++) put(32'h6000_0000 + 32'(i), 1'b0);
        cycle(1'b1, 32'hBAD0_BAD0, 4'hB, 4'hD, 1'b1, 1'b1);
        idle(1'b1);
        put(32'h7000_0001, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Asynchronous reset mid-cycle at count 2.
        put(32'h8000_0001, 1'b0);
        put(32'h8000_0002, 1'b0);
        wr_valid = 1'b0; rd_ready = 1'b0;
        #3;
        axi_areset = 1'b1;
        q.delete();
        ready_m = 1'b0;
        #1;
        check_val("arst_valid", rd_valid, 1'b0);
        check_val("arst_count", count, 3'd0);
        check_val("arst_ready", wr_ready, 1'b0);
        @(posedge axi_aclk);
        #1;
        idle(1'b0);
        axi_areset = 1'b0;
        idle(1'b0);
        put(32'hDEAD_BEEF, 1'b0);
        put(32'h1234_5678, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
